eth_frame_filter: RTL and testbench
===================================

# eth_frame_filter

Parametrised receive-side Ethernet frame filter between the RMII/bit-order front end and the payload consumers. It takes the de-preambled frame stream at DW bits per beat and checks the destination MAC against the station address, broadcast and (optionally) multicast. It can also check the EtherType. Accepted frames leave with the 14-byte header stripped; rejected frames are suppressed. Saturating accept/drop counters and per-frame status pulses are kept for debug/ILA.

## Interface
- DW, 2, bits per beat; legal values 2, 4, 8
- MY_MAC, 48'h69695A065491, station address, MSB-first wire order
- ACCEPT_BCAST, 1, accept destination FF:FF:FF:FF:FF:FF
- ACCEPT_MCAST, 0, accept any destination with group bit set (bit 40 of 48-bit dest value)
- ETYPE_FILTER, 0, 1 = also require EtherType == ETYPE
- ETYPE, 16'h0800, required EtherType when ETYPE_FILTER=1

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- axiiv  in  1  input beat valid; continuous high for one frame
- axiid  in  DW  input beat, MSB-first per byte, bytes in wire order, preamble/SFD already removed
- axiov  out  1  payload beat valid (registered)
- axiod  out  DW  payload beat (registered)
- frame_ok  out  1  one-cycle pulse: accepted frame ended
- frame_drop  out  1  one-cycle pulse: rejected or truncated frame ended
- accept_cnt  out  16  accepted frames, saturates at 16'hFFFF
- drop_cnt  out  16  dropped frames, saturates at 16'hFFFF

## Operation
- Derived constants: D = 48/DW dest beats; H = 112/DW header beats (56 / 28 / 14).
- Beat index n counts axiiv-high beats from 0 at frame start. Counter is 7 bits, frozen once n reaches H.
- prev_axiiv is a registered copy of axiiv, reset to 1. A frame starts only on a rising edge (prev_axiiv=0, axiiv=1), so a frame in progress at reset release is ignored.
- States: IDLE, DEST, HDR, PASS, DROP.
- IDLE: clears counter and shift registers. On a rising edge, captures beat 0 and goes to DEST.
- DEST: shifts beats into a 48-bit dest register. On beat D-1, evaluates the full dest, including the current beat:
  - Match when dest == MY_MAC, or (ACCEPT_BCAST and dest == all-ones), or (ACCEPT_MCAST and bit 40 set).
  - Match -> HDR; no match -> DROP.
- HDR: discards source MAC. Shifts beats D+48/DW .. H-1 into a 16-bit EtherType register. On beat H-1, evaluates the full EtherType, including the current beat:
  - ETYPE_FILTER=0, or EtherType == ETYPE -> PASS.
  - Otherwise -> DROP.
- PASS: every axiiv-high beat is forwarded. FCS bytes are forwarded unchanged; the CRC check is done downstream.
- DROP: inputs ignored until frame end.
- Frame end: any cycle with axiiv=0 in a non-IDLE state returns to IDLE.
  - From PASS: frame_ok pulses and accept_cnt increments.
  - From DEST/HDR/DROP: frame_drop pulses and drop_cnt increments. This includes truncated frames shorter than H beats.
- Counters saturate; they never wrap.
- frame_ok and frame_drop are never asserted together.

## Timing
- Reset values: axiov=0, axiod=0, frame_ok=0, frame_drop=0, both counters 0, state IDLE, prev_axiiv=1.
- Latency is exactly 1 cycle: input beat n≥H at cycle t appears on axiod with axiov=1 at cycle t+1.
- The first output beat is input beat H. No header beat is ever output.
- axiod holds its last value when axiov=0.
- Status pulses and counter updates are registered, asserted in the cycle after axiiv is first sampled low. axiov is low in that same cycle.
- Back-to-back frames need ≥1 idle cycle. A new rising edge in the cycle that frame_ok or frame_drop is high starts the next frame normally.
- Reset asserted mid-frame clears outputs immediately. After release, the remainder of that frame is discarded because prev_axiiv starts at 1.

## Test plan
- DW=2, dest=MY_MAC, EtherType 0x0800, payload 50 bytes + 4 FCS:
  - axiov first high the cycle after beat 56, high for exactly 216 beats, data equal to input beats 56..271.
  - frame_ok one pulse; accept_cnt=1.
- DW=2, dest=FF:FF:FF:FF:FF:FF -> passes. Then dest=01:00:5E:00:00:01 with ACCEPT_MCAST=0 -> axiov never high, frame_drop pulse, drop_cnt=1.
- DW=2, dest=MY_MAC, axiiv drops after beat 30 -> no axiov, frame_drop pulse, drop_cnt=1. Next frame after one idle cycle is accepted normally.
- Assert rst at beat 100 of an accepted frame, release while axiiv still high:
  - All outputs 0, counters 0, rest of the frame ignored.
  - Following frame accepted.
- DW=8, ETYPE_FILTER=1, ETYPE=16'h0800, dest=MY_MAC:
  - EtherType 0x0806 -> dropped.
  - EtherType 0x0800 -> first payload byte out the cycle after beat 14.
- Force drop_cnt to 16'hFFFE, then send 3 rejected frames -> drop_cnt reads FFFF, FFFF, FFFF; accept_cnt unchanged.

Source files
------------

// File: rtl/eth_frame_filter.sv
// eth_frame_filter: receive-side Ethernet frame filter.
// Checks destination MAC (station / broadcast / optional multicast) and an
// optional EtherType, strips the 14-byte header from accepted frames and
// suppresses rejected ones. Keeps saturating accept/drop counters and
// per-frame status pulses for debug.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for a rising edge of axiiv; counters/shifters cleared
// S_DEST | shifting destination MAC beats 0..D-1
// S_HDR  | skipping source MAC, capturing EtherType beats up to H-1
// S_PASS | forwarding every valid beat with one cycle of latency
// S_DROP | ignoring the rest of a rejected frame
//
// DW must be 2, 4 or 8 so that the header splits into whole beats.
module eth_frame_filter #(
  parameter int          DW           = 2,
  parameter logic [47:0] MY_MAC       = 48'h69695A065491,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter bit          ACCEPT_MCAST = 1'b0,
  parameter bit          ETYPE_FILTER = 1'b0,
  parameter logic [15:0] ETYPE        = 16'h0800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          axiiv,
  input  logic [DW-1:0] axiid,
  output logic          axiov,
  output logic [DW-1:0] axiod,
  output logic          frame_ok,
  output logic          frame_drop,
  output logic [15:0]   accept_cnt,
  output logic [15:0]   drop_cnt
);

  localparam int D  = 48 / DW;   // destination MAC beats
  localparam int H  = 112 / DW;  // header beats
  localparam int E0 = 96 / DW;   // first EtherType beat
  localparam logic [6:0] D_LAST  = 7'(D - 1);
  localparam logic [6:0] H_LAST  = 7'(H - 1);
  localparam logic [6:0] E_FIRST = 7'(E0);
  localparam logic [6:0] H_CNT   = 7'(H);

  typedef enum logic [2:0] {S_IDLE, S_DEST, S_HDR, S_PASS, S_DROP} state_t;

  state_t         state_q, state_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [47:0]    dest_q, dest_d;
  logic [15:0]    etype_q, etype_d;
  logic           prev_axiiv_q;
  logic           axiov_q, axiov_d;
  logic [DW-1:0]  axiod_q, axiod_d;
  logic           ok_q, ok_d;
  logic           drop_q, drop_d;
  logic [15:0]    accept_cnt_q, accept_cnt_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;

  logic           rise;
  logic [47:0]    dest_shift;
  logic [15:0]    etype_shift;
  logic           dest_match;
  logic           etype_match;

  // Decisions include the beat currently on axiid, so evaluate on the
  // shifted-in value rather than the stored one.
  assign rise        = axiiv && !prev_axiiv_q;
  assign dest_shift  = {dest_q[47-DW:0], axiid};
  assign etype_shift = {etype_q[15-DW:0], axiid};
  assign dest_match  = (dest_shift == MY_MAC)
                    || (ACCEPT_BCAST && (dest_shift == 48'hFFFF_FFFF_FFFF))
                    || (ACCEPT_MCAST && dest_shift[40]);
  assign etype_match = !ETYPE_FILTER || (etype_shift == ETYPE);

  // Next-state, datapath and status logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dest_d       = dest_q;
    etype_d      = etype_q;
    axiov_d      = 1'b0;
    axiod_d      = axiod_q;
    ok_d         = 1'b0;
    drop_d       = 1'b0;

    // Beat index freezes at H so long payloads cannot wrap it.
    if ((state_q != S_IDLE) && axiiv && (cnt_q != H_CNT)) begin
      cnt_d = cnt_q + 7'd1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        dest_d  = '0;
        etype_d = '0;
        if (rise) begin
          cnt_d   = 7'd1;
          dest_d  = {{(48-DW){1'b0}}, axiid};
          state_d = S_DEST;
        end
      end
      S_DEST: begin
        if (!axiiv) begin
          state_d = S_IDLE;
          drop_d  = 1'b1;
        end else begin
          dest_d = dest_shift;
          if (cnt_q == D_LAST) begin
            state_d = dest_match ? S_HDR : S_DROP;
          end
        end
      end
      S_HDR: begin
        if (!axiiv) begin
          state_d = S_IDLE;
          drop_d  = 1'b1;
        end else begin
          if (cnt_q >= E_FIRST) begin
            etype_d = etype_shift;
          end
          if (cnt_q == H_LAST) begin
            state_d = etype_match ? S_PASS : S_DROP;
          end
        end
      end
      S_PASS: begin
        if (!axiiv) begin
          state_d = S_IDLE;
          ok_d    = 1'b1;
        end else begin
          axiov_d = 1'b1;
          axiod_d = axiid;
        end
      end
      S_DROP: begin
        if (!axiiv) begin
          state_d = S_IDLE;
          drop_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    accept_cnt_d = accept_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (ok_d && (accept_cnt_q != 16'hFFFF)) begin
      accept_cnt_d = accept_cnt_q + 16'd1;
    end
    if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // State and output registers. prev_axiiv resets high so a frame already
  // in flight when reset releases is not mistaken for a new one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dest_q       <= '0;
      etype_q      <= '0;
      prev_axiiv_q <= 1'b1;
      axiov_q      <= 1'b0;
      axiod_q      <= '0;
      ok_q         <= 1'b0;
      drop_q       <= 1'b0;
      accept_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dest_q       <= dest_d;
      etype_q      <= etype_d;
      prev_axiiv_q <= axiiv;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      ok_q         <= ok_d;
      drop_q       <= drop_d;
      accept_cnt_q <= accept_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign frame_ok   = ok_q;
  assign frame_drop = drop_q;
  assign accept_cnt = accept_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_eth_frame_filter.sv
// Testbench for eth_frame_filter: a DW=2 instance with default filtering
// and a DW=8 instance with multicast accept and EtherType filtering.
// Frames are built as byte lists; the reference model decides acceptance
// from the header bytes and predicts each output beat and counter value.
module tb_eth_frame_filter;

  localparam logic [47:0] MAC   = 48'h69695A065491;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MCAST = 48'h01005E000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv2 = 1'b0, axiov2, ok2, drop2;
  logic [1:0]  axiid2 = '0, axiod2;
  logic [15:0] acc2, dcnt2;
  logic        axiiv8 = 1'b0, axiov8, ok8, drop8;
  logic [7:0]  axiid8 = '0, axiod8;
  logic [15:0] acc8, dcnt8;

  always #5 clk = ~clk;

  eth_frame_filter #(.DW(2)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv2), .axiid(axiid2),
    .axiov(axiov2), .axiod(axiod2), .frame_ok(ok2), .frame_drop(drop2),
    .accept_cnt(acc2), .drop_cnt(dcnt2)
  );

  eth_frame_filter #(.DW(8), .ACCEPT_MCAST(1'b1), .ETYPE_FILTER(1'b1),
                     .ETYPE(16'h0800)) dut8 (
    .clk(clk), .rst(rst), .axiiv(axiiv8), .axiid(axiid8),
    .axiov(axiov8), .axiod(axiod8), .frame_ok(ok8), .frame_drop(drop8),
    .accept_cnt(acc8), .drop_cnt(dcnt8)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         exp_acc [2];
  int         exp_drop [2];
  logic [7:0] last_out [2];
  logic [7:0] frm [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] dest, input logic [15:0] et, input int npay);
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(dest[i*8 +: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'($urandom()));
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    for (int i = 0; i < npay + 4; i++) frm.push_back(8'($urandom()));
  endtask

  // Acceptance decided from header bytes alone; frames shorter than the
  // header can never be accepted.
  function automatic bit model_accept(input int w, input int len);
    logic [47:0] d;
    logic [15:0] et;
    bit dest_ok, et_ok;
    d       = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
    et      = {frm[12], frm[13]};
    dest_ok = (d == MAC) || (d == BCAST) || ((w == 8) && frm[0][0]);
    et_ok   = (w == 2) || (et == 16'h0800);
    return dest_ok && et_ok && (len >= 112 / w);
  endfunction

  function automatic logic [7:0] beat_of(input int w, input int k);
    int per, sh;
    logic [7:0] b;
    per = 8 / w;
    b   = frm[k / per];
    sh  = 8 - w * ((k % per) + 1);
    return 8'((int'(b) >> sh) & ((1 << w) - 1));
  endfunction

  task automatic drive(input int w, input logic v, input logic [7:0] d);
    if (w == 2) begin
      axiiv2 = v;
      axiid2 = d[1:0];
    end else begin
      axiiv8 = v;
      axiid8 = d;
    end
  endtask

  task automatic get(input int w, output logic ov, output logic [7:0] od,
                     output logic ok, output logic dr,
                     output logic [15:0] ac, output logic [15:0] dc);
    if (w == 2) begin
      ov = axiov2; od = {6'b0, axiod2}; ok = ok2; dr = drop2; ac = acc2; dc = dcnt2;
    end else begin
      ov = axiov8; od = axiod8; ok = ok8; dr = drop8; ac = acc8; dc = dcnt8;
    end
  endtask

  // Sends the first len beats of frm, optionally pulsing reset right after
  // beat rst_at is presented, then ends the frame with one idle cycle.
  task automatic send(input int w, input int len, input int rst_at);
    int h, idx;
    bit acc, killed;
    logic ov, ok, dr;
    logic [7:0] od, bt;
    logic [15:0] ac, dc;
    h      = 112 / w;
    idx    = (w == 8) ? 1 : 0;
    acc    = model_accept(w, len);
    killed = 1'b0;
    for (int k = 0; k < len; k++) begin
      bt = beat_of(w, k);
      drive(w, 1'b1, bt);
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        get(w, ov, od, ok, dr, ac, dc);
        check("rst_axiov", 32'(ov), 0);
        check("rst_axiod", 32'(od), 0);
        check("rst_pulses", 32'({ok, dr}), 0);
        check("rst_acc_cnt", 32'(ac), 0);
        check("rst_drop_cnt", 32'(dc), 0);
        exp_acc  = '{0, 0};
        exp_drop = '{0, 0};
        last_out = '{8'h00, 8'h00};
        killed   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      @(posedge clk);
      #1;
      get(w, ov, od, ok, dr, ac, dc);
      if (!killed && acc && (k >= h)) begin
        check("beat_valid", 32'(ov), 1);
        check("beat_data", 32'(od), 32'(bt));
        last_out[idx] = bt;
      end else begin
        check("no_valid", 32'(ov), 0);
        check("hold_data", 32'(od), 32'(last_out[idx]));
      end
      check("mid_pulses", 32'({ok, dr}), 0);
    end
    drive(w, 1'b0, 8'($urandom()));
    @(posedge clk);
    #1;
    if (!killed && acc && exp_acc[idx] < 16'hFFFF) exp_acc[idx]++;
    if (!killed && !acc && exp_drop[idx] < 16'hFFFF) exp_drop[idx]++;
    get(w, ov, od, ok, dr, ac, dc);
    check("end_axiov", 32'(ov), 0);
    check("end_hold", 32'(od), 32'(last_out[idx]));
    check("frame_ok", 32'(ok), 32'(!killed && acc));
    check("frame_drop", 32'(dr), 32'(!killed && !acc));
    check("accept_cnt", 32'(ac), 32'(exp_acc[idx]));
    check("drop_cnt", 32'(dc), 32'(exp_drop[idx]));
  endtask

  initial begin
    logic ov, ok, dr;
    logic [7:0] od;
    logic [15:0] ac, dc;
    logic [47:0] dst;
    logic [15:0] et;
    int w, len, sel;

    exp_acc  = '{0, 0};
    exp_drop = '{0, 0};
    last_out = '{8'h00, 8'h00};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    get(2, ov, od, ok, dr, ac, dc);
    check("reset_axiov", 32'(ov), 0);
    check("reset_axiod", 32'(od), 0);
    check("reset_pulses", 32'({ok, dr}), 0);
    check("reset_acc", 32'(ac), 0);
    check("reset_drop", 32'(dc), 0);
    @(posedge clk);
    #1;

    // Station address, 50-byte payload + FCS: 272 beats, 216 forwarded.
    build(MAC, 16'h0800, 50);
    send(2, 272, -1);
    build(BCAST, 16'h1234, 46);
    send(2, frm.size() * 4, -1);
    build(MCAST, 16'h0800, 46);
    send(2, frm.size() * 4, -1);

    // Truncated after beat 30, then a normal frame after one idle cycle.
    build(MAC, 16'h0800, 46);
    send(2, 31, -1);
    build(MAC, 16'h0800, 46);
    send(2, frm.size() * 4, -1);

    // Reset at beat 100 of an accepted frame, then a normal frame.
    build(MAC, 16'h0800, 50);
    send(2, 272, 100);
    build(MAC, 16'h0800, 50);
    send(2, 272, -1);

    // DW=8 with EtherType filtering.
    build(MAC, 16'h0806, 46);
    send(8, frm.size(), -1);
    build(MAC, 16'h0800, 46);
    send(8, frm.size(), -1);

    // Randomised frames on both widths.
    for (int i = 0; i < 30; i++) begin
      w   = ($urandom_range(0, 1) == 0) ? 2 : 8;
      sel = $urandom_range(0, 3);
      dst = (sel == 0) ? MAC : (sel == 1) ? BCAST : (sel == 2) ? MCAST
          : {$urandom(), 16'($urandom())};
      sel = $urandom_range(0, 2);
      et  = (sel == 0) ? 16'h0800 : (sel == 1) ? 16'h0806 : 16'($urandom());
      build(dst, et, $urandom_range(46, 60));
      len = frm.size() * (8 / w);
      if ($urandom_range(0, 5) == 0) len = $urandom_range(1, len);
      send(w, len, -1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Drop counter saturation.
    force dut.drop_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.drop_cnt_q;
    exp_drop[0] = 16'hFFFE;
    @(posedge clk);
    #1;
    check("forced_drop_cnt", 32'(dcnt2), 32'(exp_drop[0]));
    for (int i = 0; i < 3; i++) begin
      build(48'h020000000001, 16'h0800, 46);
      send(2, frm.size() * 4, -1);
    end
    check("sat_drop_cnt", 32'(dcnt2), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
